// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - rd_flag load-type codes
//   - legal store-size wmask constants
//   - FSM state encoding
//   - access_bad(): size/alignment legality check for a captured request
package lsu_pkg;

   localparam logic [2:0] RD_NONE = 3'd0;
   localparam logic [2:0] RD_LW   = 3'd1;
   localparam logic [2:0] RD_LD   = 3'd2;
   localparam logic [2:0] RD_LB   = 3'd3;
   localparam logic [2:0] RD_LH   = 3'd4;
   localparam logic [2:0] RD_LBU  = 3'd5;
   localparam logic [2:0] RD_LHU  = 3'd6;
   localparam logic [2:0] RD_LWU  = 3'd7;

   localparam logic [7:0] WMASK_B = 8'h01;
   localparam logic [7:0] WMASK_H = 8'h03;
   localparam logic [7:0] WMASK_W = 8'h0F;
   localparam logic [7:0] WMASK_D = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // 1 when the access has an illegal size code or is misaligned for its size.
   function automatic logic access_bad(input logic       we,
                                       input logic [7:0] wmask,
                                       input logic [2:0] rd_flag,
                                       input logic [2:0] off);
      logic bad;
      bad = 1'b1;
      if (we) begin
         case (wmask)
            WMASK_B: bad = 1'b0;
            WMASK_H: bad = off[0];
            WMASK_W: bad = |off[1:0];
            WMASK_D: bad = |off;
            default: bad = 1'b1;
         endcase
      end else begin
         case (rd_flag)
            RD_LB, RD_LBU:        bad = 1'b0;
            RD_LH, RD_LHU:        bad = off[0];
            RD_LW, RD_LWU:        bad = |off[1:0];
            RD_LD:                bad = |off;
            default:              bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extractor.
//   rsp_data  in  64 : aligned doubleword from memory
//   offset    in  3  : byte offset of the access within the doubleword
//   rd_flag   in  3  : load-type code
//   ext_data  out 64 : selected lane, truncated and sign/zero extended
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [63:0] rsp_data,
   input  logic [2:0]  offset,
   input  logic [2:0]  rd_flag,
   output logic [63:0] ext_data
);

   logic [63:0] lane;

   always_comb begin
      lane     = rsp_data >> {offset, 3'b000};
      ext_data = '0;
      case (rd_flag)
         RD_LB:   ext_data = {{56{lane[7]}},  lane[7:0]};
         RD_LBU:  ext_data = {56'd0,          lane[7:0]};
         RD_LH:   ext_data = {{48{lane[15]}}, lane[15:0]};
         RD_LHU:  ext_data = {48'd0,          lane[15:0]};
         RD_LW:   ext_data = {{32{lane[31]}}, lane[31:0]};
         RD_LWU:  ext_data = {32'd0,          lane[31:0]};
         RD_LD:   ext_data = lane;
         default: ext_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit. Accepts one load/store from execute, runs a single
// valid/ready transaction on the data-memory port and returns load data to
// writeback. Stalls the core through lsu_busy while a transaction is open.
//
// Optional feature: define LSU_TIMEOUT_EN to bound the wait for a memory
// response to TIMEOUT cycles (timeout reports lsu_err).
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready                 request handshake from execute
//   req_we, req_addr, req_wdata,
//   req_wmask, req_rd_flag, req_rd      request fields
//   mem_req_valid/mem_req_ready         memory request handshake
//   mem_we, mem_addr, mem_wdata,
//   mem_wstrb                           memory request fields (lane-shifted)
//   mem_rsp_valid, mem_rsp_data,
//   mem_rsp_err                         memory response
//   wb_valid, wb_we, wb_rd, wb_data     writeback (one-cycle pulse)
//   lsu_err                             error flag, valid with wb_valid
//   lsu_busy                            state is not IDLE
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | memory request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
// RESP  | writeback pulse this cycle
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   input  logic [2:0]  req_rd_flag,
   input  logic [4:0]  req_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        lsu_err,
   output logic        lsu_busy
);

   lsu_state_e  state_q;
   logic        we_q;
   logic [2:0]  off_q;
   logic [2:0]  rd_flag_q;
   logic [4:0]  rd_q;
   logic        req_bad;
   logic [63:0] ext_data;

`ifdef LSU_TIMEOUT_EN
   // Down-counter loaded on entry to WAIT; terminal count 0 ends the wait
   // after exactly TIMEOUT WAIT cycles.
   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);
   logic [7:0] tmr_q;
`endif

   assign req_ready = (state_q == ST_IDLE);
   assign lsu_busy  = (state_q != ST_IDLE);
   assign req_bad   = access_bad(req_we, req_wmask, req_rd_flag, req_addr[2:0]);

   lsu_load_ext u_load_ext (
      .rsp_data (mem_rsp_data),
      .offset   (off_q),
      .rd_flag  (rd_flag_q),
      .ext_data (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         we_q          <= 1'b0;
         off_q         <= '0;
         rd_flag_q     <= '0;
         rd_q          <= '0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wstrb     <= '0;
         wb_valid      <= 1'b0;
         wb_we         <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         lsu_err       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         tmr_q         <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  off_q     <= req_addr[2:0];
                  rd_flag_q <= req_rd_flag;
                  rd_q      <= req_rd;
                  if (req_bad) begin
                     // Rejected without touching memory.
                     state_q  <= ST_RESP;
                     wb_valid <= 1'b1;
                     wb_we    <= 1'b0;
                     wb_rd    <= req_rd;
                     wb_data  <= '0;
                     lsu_err  <= 1'b1;
                  end else begin
                     state_q       <= ST_REQ;
                     mem_req_valid <= 1'b1;
                     mem_we        <= req_we;
                     mem_addr      <= {req_addr[63:3], 3'b000};
                     mem_wdata     <= req_we ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;
                     mem_wstrb     <= req_we ? (req_wmask << req_addr[2:0]) : '0;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  state_q       <= ST_WAIT;
                  mem_req_valid <= 1'b0;
                  mem_we        <= 1'b0;
                  mem_addr      <= '0;
                  mem_wdata     <= '0;
                  mem_wstrb     <= '0;
`ifdef LSU_TIMEOUT_EN
                  tmr_q         <= TMR_LOAD;
`endif
               end
            end
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  state_q  <= ST_RESP;
                  wb_valid <= 1'b1;
                  wb_we    <= !we_q && !mem_rsp_err;
                  wb_rd    <= rd_q;
                  wb_data  <= (!we_q && !mem_rsp_err) ? ext_data : '0;
                  lsu_err  <= mem_rsp_err;
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmr_q == 8'd0) begin
                  state_q  <= ST_RESP;
                  wb_valid <= 1'b1;
                  wb_we    <= 1'b0;
                  wb_rd    <= rd_q;
                  wb_data  <= '0;
                  lsu_err  <= 1'b1;
               end else begin
                  tmr_q <= tmr_q - 8'd1;
               end
`endif
            end
            ST_RESP: begin
               state_q  <= ST_IDLE;
               wb_valid <= 1'b0;
               wb_we    <= 1'b0;
               wb_rd    <= '0;
               wb_data  <= '0;
               lsu_err  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic [2:0]  req_rd_flag = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_rsp_valid = 1'b0;
   logic [63:0] mem_rsp_data = '0;
   logic        mem_rsp_err = 1'b0;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        lsu_err;
   logic        lsu_busy;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(10)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wmask     (req_wmask),
      .req_rd_flag   (req_rd_flag),
      .req_rd        (req_rd),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .mem_rsp_err   (mem_rsp_err),
      .wb_valid      (wb_valid),
      .wb_we         (wb_we),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .lsu_err       (lsu_err),
      .lsu_busy      (lsu_busy)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Access size in bytes from the architectural rules; 0 = illegal.
   function automatic int size_of(input logic we, input logic [7:0] wmask, input logic [2:0] code);
      if (we) begin
         case (wmask)
            8'h01: return 1;
            8'h03: return 2;
            8'h0F: return 4;
            8'hFF: return 8;
            default: return 0;
         endcase
      end
      case (code)
         3'd3, 3'd5: return 1;
         3'd4, 3'd6: return 2;
         3'd1, 3'd7: return 4;
         3'd2:       return 8;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] data, input logic [2:0] off, input logic [2:0] code);
      int          sz;
      logic [63:0] lane, m, v;
      logic        sgn;
      sz   = size_of(1'b0, 8'h00, code);
      sgn  = (code == 3'd1) || (code == 3'd3) || (code == 3'd4);
      lane = data >> (8 * int'(off));
      m    = (sz == 8) ? {64{1'b1}} : ((64'd1 << (8 * sz)) - 64'd1);
      v    = lane & m;
      if (sgn && sz < 8 && v[8*sz-1]) v = v | ~m;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one access starting at a negedge; returns at a negedge with the unit idle.
   task automatic do_access(input string name, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wmask, input logic [2:0] code,
                            input logic [4:0] rd, input logic [63:0] rdata, input logic err,
                            input int rdy_dly, input int rsp_dly);
      int          sz;
      logic        bad;
      logic [2:0]  off;
      logic [63:0] exp_addr;
      logic        ld_ok;
      sz  = size_of(we, wmask, code);
      off = addr[2:0];
      bad = 1'b1;
      if (sz != 0) bad = (int'(off) % sz) != 0;
      exp_addr = addr & ~64'h7;
      ld_ok = !we && !err;

      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_wmask = wmask; req_rd_flag = code; req_rd = rd;
      check_val({name, ".req_ready_idle"}, req_ready, 1);
      step();
      req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_rd = ~rd;
      req_we = ~we; req_rd_flag = ~code; req_wmask = ~wmask;
      @(negedge clk);

      if (bad) begin
         check_val({name, ".err_wb_valid"}, wb_valid, 1);
         check_val({name, ".err_lsu_err"}, lsu_err, 1);
         check_val({name, ".err_wb_we"}, wb_we, 0);
         check_val({name, ".err_wb_rd"}, wb_rd, rd);
         check_val({name, ".err_no_mem"}, mem_req_valid, 0);
         check_val({name, ".err_ready"}, req_ready, 0);
         step();
         @(negedge clk);
         check_val({name, ".err_pulse_end"}, wb_valid, 0);
         check_val({name, ".err_ready_back"}, req_ready, 1);
         return;
      end

      check_val({name, ".busy"}, lsu_busy, 1);
      check_val({name, ".ready_low"}, req_ready, 0);
      check_val({name, ".mem_we"}, mem_we, we);
      if (we) begin
         check_val({name, ".mem_wstrb"}, mem_wstrb, 64'(8'(wmask << off)));
         check_val({name, ".mem_wdata"}, mem_wdata, wdata << (8 * int'(off)));
      end
      for (int i = 0; i <= rdy_dly; i++) begin
         check_val({name, ".mem_req_valid"}, mem_req_valid, 1);
         check_val({name, ".mem_addr"}, mem_addr, exp_addr);
         check_val({name, ".no_wb_req"}, wb_valid, 0);
         mem_req_ready = (i == rdy_dly);
         mem_rsp_valid = (i < rdy_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rsp_data  = {$urandom, $urandom};
         step();
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         @(negedge clk);
      end
      check_val({name, ".req_dropped"}, mem_req_valid, 0);
      for (int i = 0; i <= rsp_dly; i++) begin
         check_val({name, ".no_wb_wait"}, wb_valid, 0);
         check_val({name, ".busy_wait"}, lsu_busy, 1);
         mem_rsp_valid = (i == rsp_dly);
         mem_rsp_data  = (i == rsp_dly) ? rdata : {$urandom, $urandom};
         mem_rsp_err   = (i == rsp_dly) ? err : 1'b0;
         step();
         mem_rsp_valid = 1'b0;
         mem_rsp_err   = 1'b0;
         mem_rsp_data  = {$urandom, $urandom};
         @(negedge clk);
      end
      check_val({name, ".wb_valid"}, wb_valid, 1);
      check_val({name, ".wb_we"}, wb_we, ld_ok);
      check_val({name, ".lsu_err"}, lsu_err, err);
      check_val({name, ".wb_rd"}, wb_rd, rd);
      if (we) check_val({name, ".wb_data_st"}, wb_data, 0);
      else if (!err) check_val({name, ".wb_data"}, wb_data, model_load(rdata, off, code));
      step();
      @(negedge clk);
      check_val({name, ".pulse_end"}, wb_valid, 0);
      check_val({name, ".ready_back"}, req_ready, 1);
      check_val({name, ".idle_busy"}, lsu_busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  masks [4];
      logic        r_we;
      logic [7:0]  r_mask;
      logic [63:0] r_addr;
      masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F; masks[3] = 8'hFF;

      #12;
      @(negedge clk);
      check_val("rst.req_ready", req_ready, 1);
      check_val("rst.busy", lsu_busy, 0);
      check_val("rst.mem_req_valid", mem_req_valid, 0);
      check_val("rst.mem_addr", mem_addr, 0);
      check_val("rst.wb_valid", wb_valid, 0);
      check_val("rst.wb_data", wb_data, 0);
      check_val("rst.lsu_err", lsu_err, 0);
      rst_n = 1'b1;
      step();
      @(negedge clk);

      do_access("ld", 1'b0, 64'h8000_0010, '0, 8'hFF, 3'd2, 5'd7, 64'h1122334455667788, 1'b0, 0, 0);
      check_val("ld.const", model_load(64'h1122334455667788, 3'd0, 3'd2), 64'h1122334455667788);
      do_access("lb", 1'b0, 64'h8000_0003, '0, 8'h01, 3'd3, 5'd9, 64'h0000_0000_8000_0000, 1'b0, 0, 0);
      do_access("lbu", 1'b0, 64'h8000_0003, '0, 8'h01, 3'd5, 5'd10, 64'h0000_0000_8000_0000, 1'b0, 1, 1);
      do_access("sw", 1'b1, 64'h8000_0004, 64'hDEADBEEF, 8'h0F, 3'd0, 5'd0, '0, 1'b0, 0, 0);
      do_access("lw_mis", 1'b0, 64'h8000_0002, '0, 8'h0F, 3'd1, 5'd3, '0, 1'b0, 0, 0);
      do_access("ld_nofl", 1'b0, 64'h8000_0008, '0, 8'hFF, 3'd0, 5'd4, '0, 1'b0, 0, 0);
      do_access("st_badmask", 1'b1, 64'h8000_0000, 64'h1, 8'h07, 3'd0, 5'd5, '0, 1'b0, 0, 0);
      do_access("ld_stall_err", 1'b0, 64'h8000_0020, '0, 8'hFF, 3'd2, 5'd6, 64'h55, 1'b1, 5, 2);

      // Reset in WAIT, then a late response.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0040; req_rd_flag = 3'd2; req_rd = 5'd1;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      @(negedge clk);
      check_val("rstw.in_wait", lsu_busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("rstw.ready", req_ready, 1);
      check_val("rstw.busy", lsu_busy, 0);
      check_val("rstw.wb_valid", wb_valid, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hABCD;
      step();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_val("rstw.late_wb", wb_valid, 0);
      check_val("rstw.late_ready", req_ready, 1);
      step();
      @(negedge clk);
      check_val("rstw.late_wb2", wb_valid, 0);

`ifdef LSU_TIMEOUT_EN
      begin
         int waits;
         waits = 0;
         req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0080; req_rd_flag = 3'd2; req_rd = 5'd2;
         step();
         req_valid = 1'b0;
         @(negedge clk);
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         @(negedge clk);
         while (!wb_valid && waits < 50) begin
            waits++;
            step();
            @(negedge clk);
         end
         check_val("tmo.wait_cycles", waits, 10);
         check_val("tmo.lsu_err", lsu_err, 1);
         check_val("tmo.wb_we", wb_we, 0);
         step();
         @(negedge clk);
      end
`endif

      for (int n = 0; n < 60; n++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_mask = ($urandom_range(0, 9) == 0) ? 8'h07 : masks[$urandom_range(0, 3)];
         r_addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)} + 64'($urandom_range(0, 7));
         do_access("rnd", r_we, r_addr, {$urandom, $urandom}, r_mask, 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
